// File: rtl/gate_bist.sv
// ---------------------------------------------------------------------------
// gate_bist - built-in self-test engine for a small combinational gate.
//
// Drives every input vector of the gate under test in ascending binary order,
// holds each one for SETTLE+1 cycles, samples the gate output on the last edge
// of that window and compares it with the expected truth table EXPECT.
// At the end of a run it reports pass/fail, the number of mismatches and the
// lowest failing vector.
//
// Parameters
//   N_IN    number of gate inputs (1..4)
//   EXPECT  expected truth table; bit i is the expected dut_out for dut_in == i
//   SETTLE  extra cycles each vector is held before sampling (0..255)
//
// Ports
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   start             run request, sampled only while idle
//   dut_in            vector driven to the gate (bit 0 -> input a, ...)
//   dut_out           gate output, assumed combinational from dut_in
//   busy              high while a run is in progress
//   done              one-cycle pulse in the cycle after busy falls
//   pass              last completed run had zero mismatches
//   fail_count        mismatches in the last run (0..2**N_IN, never wraps)
//   first_fail_idx    lowest vector index that mismatched
//   first_fail_valid  first_fail_idx is meaningful
// ---------------------------------------------------------------------------
module gate_bist #(
   parameter int unsigned              N_IN   = 2,
   parameter logic [(2**N_IN)-1:0]     EXPECT = 4'b1000,
   parameter int unsigned              SETTLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [N_IN-1:0]   dut_in,
   input  logic              dut_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     fail_count,
   output logic [N_IN-1:0]   first_fail_idx,
   output logic              first_fail_valid
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   // Highest vector index; the run ends after this vector is compared.
   localparam logic [N_IN-1:0] LAST_IDX = '1;
   localparam logic [7:0]      SETTLE_CNT = 8'(SETTLE);

   state_t            state;
   logic [N_IN-1:0]   idx;
   logic [7:0]        cnt;

   // Compare result for the current edge. Only meaningful on the sampling
   // edge of a vector (RUN with the settle counter exhausted).
   logic              sample;
   logic              mismatch;
   logic [N_IN:0]     fail_next;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      sample    = 1'b0;
      mismatch  = 1'b0;
      fail_next = fail_count;
      if (state == RUN && cnt == '0) begin
         sample    = 1'b1;
         mismatch  = (dut_out != EXPECT[idx]);
         // At most 2**N_IN compares per run, so N_IN+1 bits cannot wrap.
         fail_next = fail_count + {{N_IN{1'b0}}, mismatch};
      end
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register sees the pre-edge values of the others, independent of the
   // order of statements in this block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         idx              <= '0;
         cnt              <= '0;
         dut_in           <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         fail_count       <= '0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         // done is a single-cycle pulse; only the final compare re-arms it.
         done <= 1'b0;

         case (state)
            IDLE: begin
               // Accepted also in the done cycle, which gives back-to-back
               // runs when start is held high.
               if (start) begin
                  state            <= RUN;
                  idx              <= '0;
                  dut_in           <= '0;
                  cnt              <= SETTLE_CNT;
                  busy             <= 1'b1;
                  pass             <= 1'b0;
                  fail_count       <= '0;
                  first_fail_idx   <= '0;
                  first_fail_valid <= 1'b0;
               end
            end

            RUN: begin
               if (!sample) begin
                  // Still settling: hold the vector, count down.
                  cnt <= cnt - 1'b1;
               end else begin
                  fail_count <= fail_next;
                  if (mismatch && !first_fail_valid) begin
                     first_fail_idx   <= idx;
                     first_fail_valid <= 1'b1;
                  end

                  if (idx != LAST_IDX) begin
                     idx    <= idx + 1'b1;
                     dut_in <= idx + 1'b1;
                     cnt    <= SETTLE_CNT;
                  end else begin
                     state  <= IDLE;
                     idx    <= '0;
                     dut_in <= '0;
                     busy   <= 1'b0;
                     done   <= 1'b1;
                     // Includes the compare made on this very edge.
                     pass   <= (fail_next == '0);
                  end
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               dut_in <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_bist.sv
// ---------------------------------------------------------------------------
// tb_gate_bist - directed self-checking bench for gate_bist.
//
// Five engines share clock and reset, each beside its own gate model:
//   0: And gate,  EXPECT=1000, SETTLE=1  (correct table)
//   1: And gate,  EXPECT=1001, SETTLE=1  (one wrong table entry)
//   2: stuck-at-1 output, EXPECT=1000, SETTLE=1
//   3: And gate,  EXPECT=1000, SETTLE=0
//   4: And gate,  EXPECT=0111, SETTLE=2  (every vector mismatches)
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_gate_bist;

   localparam int NI = 5;

   logic       clk;
   logic       rst_n;
   logic       start            [NI];
   logic [1:0] dut_in           [NI];
   logic       gate_out         [NI];
   logic       busy             [NI];
   logic       done             [NI];
   logic       pass             [NI];
   logic [2:0] fail_count       [NI];
   logic [1:0] first_fail_idx   [NI];
   logic       first_fail_valid [NI];

   int errors = 0;
   int checks = 0;

   // Run observation shared by the scenario tasks.
   int         sel;
   int         cyc;
   int         busy_dones;
   logic [1:0] seq [64];
   logic [31:0] seq_packed;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Gate models beside each engine.
   assign gate_out[0] = &dut_in[0];
   assign gate_out[1] = &dut_in[1];
   assign gate_out[2] = 1'b1;
   assign gate_out[3] = &dut_in[3];
   assign gate_out[4] = &dut_in[4];

   gate_bist #(.N_IN(2), .EXPECT(4'b1000), .SETTLE(1)) u_and (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .dut_in(dut_in[0]),
      .dut_out(gate_out[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .fail_count(fail_count[0]), .first_fail_idx(first_fail_idx[0]),
      .first_fail_valid(first_fail_valid[0]));

   gate_bist #(.N_IN(2), .EXPECT(4'b1001), .SETTLE(1)) u_badtab (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .dut_in(dut_in[1]),
      .dut_out(gate_out[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .fail_count(fail_count[1]), .first_fail_idx(first_fail_idx[1]),
      .first_fail_valid(first_fail_valid[1]));

   gate_bist #(.N_IN(2), .EXPECT(4'b1000), .SETTLE(1)) u_stuck (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .dut_in(dut_in[2]),
      .dut_out(gate_out[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
      .fail_count(fail_count[2]), .first_fail_idx(first_fail_idx[2]),
      .first_fail_valid(first_fail_valid[2]));

   gate_bist #(.N_IN(2), .EXPECT(4'b1000), .SETTLE(0)) u_fast (
      .clk(clk), .rst_n(rst_n), .start(start[3]), .dut_in(dut_in[3]),
      .dut_out(gate_out[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
      .fail_count(fail_count[3]), .first_fail_idx(first_fail_idx[3]),
      .first_fail_valid(first_fail_valid[3]));

   gate_bist #(.N_IN(2), .EXPECT(4'b0111), .SETTLE(2)) u_allbad (
      .clk(clk), .rst_n(rst_n), .start(start[4]), .dut_in(dut_in[4]),
      .dut_out(gate_out[4]), .busy(busy[4]), .done(done[4]), .pass(pass[4]),
      .fail_count(fail_count[4]), .first_fail_idx(first_fail_idx[4]),
      .first_fail_valid(first_fail_valid[4]));

   // ---------------------------------------------------------------- helpers
   task automatic set_start(input int s, input logic v);
      start[s] = v;
   endtask

   // Pulse start for one cycle; returns at the falling edge of busy cycle 1.
   task automatic pulse_start(input int s);
      set_start(s, 1'b1);
      @(negedge clk);
      set_start(s, 1'b0);
   endtask

   // Record dut_in every busy cycle until busy falls (bounded). If pa > 0,
   // start is driven high during busy cycles pa and pb and low otherwise.
   // Returns at the falling edge of the first cycle with busy low.
   task automatic watch_run(input int pa, input int pb);
      cyc        = 0;
      busy_dones = 0;
      seq_packed = '0;
      while (busy[sel] && cyc < 64) begin
         seq[cyc]   = dut_in[sel];
         seq_packed = {seq_packed[29:0], dut_in[sel]};
         if (done[sel]) busy_dones++;
         cyc++;
         if (pa > 0) set_start(sel, (cyc == pa) || (cyc == pb));
         @(negedge clk);
      end
      if (pa > 0) set_start(sel, 1'b0);
   endtask

   // ------------------------------------------------------------- scenarios
   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) start[i] = 1'b0;
      #3;
      for (int i = 0; i < NI; i++) begin
         checks++;
         if ({busy[i], done[i], pass[i], fail_count[i], first_fail_idx[i],
              first_fail_valid[i], dut_in[i]} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs inst=%0d got busy=%b done=%b pass=%b fc=%0d ffi=%0d ffv=%b dut_in=%0d want all 0",
                     i, busy[i], done[i], pass[i], fail_count[i], first_fail_idx[i],
                     first_fail_valid[i], dut_in[i]);
         end
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy[0], done[0]);
      end
   endtask

   task automatic test_and_pass();
      sel = 0;
      pulse_start(0);
      watch_run(0, 0);
      checks++;
      if (cyc !== 8) begin
         errors++; $display("FAIL and_busy_len got %0d want 8", cyc);
      end
      checks++;
      if (seq_packed[15:0] !== 16'h05AF) begin
         errors++; $display("FAIL and_dut_in_seq got %h want 05af", seq_packed[15:0]);
      end
      checks++;
      if (done[0] !== 1'b1 || busy_dones !== 0 || dut_in[0] !== 2'd0) begin
         errors++;
         $display("FAIL and_done got done=%b early_dones=%0d dut_in=%0d want 1 0 0",
                  done[0], busy_dones, dut_in[0]);
      end
      checks++;
      if (pass[0] !== 1'b1 || fail_count[0] !== 3'd0 || first_fail_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL and_result got pass=%b fc=%0d ffv=%b want 1 0 0",
                  pass[0], fail_count[0], first_fail_valid[0]);
      end
      @(negedge clk);
      checks++;
      if (done[0] !== 1'b0 || pass[0] !== 1'b1) begin
         errors++; $display("FAIL and_done_width got done=%b pass=%b want 0 1", done[0], pass[0]);
      end
   endtask

   task automatic test_expect_mismatch();
      sel = 1;
      pulse_start(1);
      watch_run(0, 0);
      checks++;
      if (cyc !== 8 || done[1] !== 1'b1) begin
         errors++; $display("FAIL badtab_run got len=%0d done=%b want 8 1", cyc, done[1]);
      end
      checks++;
      if (pass[1] !== 1'b0 || fail_count[1] !== 3'd1 || first_fail_idx[1] !== 2'd0 ||
          first_fail_valid[1] !== 1'b1) begin
         errors++;
         $display("FAIL badtab_result got pass=%b fc=%0d ffi=%0d ffv=%b want 0 1 0 1",
                  pass[1], fail_count[1], first_fail_idx[1], first_fail_valid[1]);
      end
   endtask

   task automatic test_stuck_high();
      sel = 2;
      pulse_start(2);
      watch_run(0, 0);
      checks++;
      if (pass[2] !== 1'b0 || fail_count[2] !== 3'd3 || first_fail_idx[2] !== 2'd0 ||
          first_fail_valid[2] !== 1'b1) begin
         errors++;
         $display("FAIL stuck_result got pass=%b fc=%0d ffi=%0d ffv=%b want 0 3 0 1",
                  pass[2], fail_count[2], first_fail_idx[2], first_fail_valid[2]);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (pass[2] !== 1'b0 || fail_count[2] !== 3'd3 || first_fail_idx[2] !== 2'd0 ||
          first_fail_valid[2] !== 1'b1 || busy[2] !== 1'b0) begin
         errors++;
         $display("FAIL stuck_hold got pass=%b fc=%0d ffi=%0d ffv=%b busy=%b want 0 3 0 1 0",
                  pass[2], fail_count[2], first_fail_idx[2], first_fail_valid[2], busy[2]);
      end
   endtask

   task automatic test_all_fail();
      sel = 4;
      pulse_start(4);
      watch_run(0, 0);
      checks++;
      if (cyc !== 12) begin
         errors++; $display("FAIL allbad_busy_len got %0d want 12", cyc);
      end
      checks++;
      if (seq_packed[23:0] !== 24'h015ABF) begin
         errors++; $display("FAIL allbad_dut_in_seq got %h want 015abf", seq_packed[23:0]);
      end
      checks++;
      if (pass[4] !== 1'b0 || fail_count[4] !== 3'd4 || first_fail_idx[4] !== 2'd0 ||
          first_fail_valid[4] !== 1'b1) begin
         errors++;
         $display("FAIL allbad_result got pass=%b fc=%0d ffi=%0d ffv=%b want 0 4 0 1",
                  pass[4], fail_count[4], first_fail_idx[4], first_fail_valid[4]);
      end
   endtask

   task automatic test_back_to_back();
      sel = 3;
      set_start(3, 1'b1);            // held through the whole first run
      @(negedge clk);
      watch_run(0, 0);
      checks++;
      if (cyc !== 4 || seq_packed[7:0] !== 8'h1B) begin
         errors++; $display("FAIL fast_run1 got len=%0d seq=%h want 4 1b", cyc, seq_packed[7:0]);
      end
      checks++;
      if (done[3] !== 1'b1 || busy[3] !== 1'b0 || pass[3] !== 1'b1) begin
         errors++;
         $display("FAIL fast_done1 got done=%b busy=%b pass=%b want 1 0 1", done[3], busy[3], pass[3]);
      end
      @(negedge clk);
      checks++;
      if (busy[3] !== 1'b1 || done[3] !== 1'b0 || dut_in[3] !== 2'd0 || pass[3] !== 1'b0) begin
         errors++;
         $display("FAIL fast_restart got busy=%b done=%b dut_in=%0d pass=%b want 1 0 0 0",
                  busy[3], done[3], dut_in[3], pass[3]);
      end
      set_start(3, 1'b0);
      watch_run(0, 0);
      checks++;
      if (cyc !== 4 || seq_packed[7:0] !== 8'h1B || done[3] !== 1'b1 || pass[3] !== 1'b1) begin
         errors++;
         $display("FAIL fast_run2 got len=%0d seq=%h done=%b pass=%b want 4 1b 1 1",
                  cyc, seq_packed[7:0], done[3], pass[3]);
      end
      @(negedge clk);
      checks++;
      if (busy[3] !== 1'b0 || done[3] !== 1'b0) begin
         errors++; $display("FAIL fast_stop got busy=%b done=%b want 0 0", busy[3], done[3]);
      end
   endtask

   task automatic test_reset_mid_run();
      logic saw_done;
      sel = 0;
      pulse_start(0);                // now in busy cycle 1
      repeat (2) @(negedge clk);     // busy cycle 3
      checks++;
      if (busy[0] !== 1'b1 || dut_in[0] !== 2'd1) begin
         errors++; $display("FAIL midrst_pre got busy=%b dut_in=%0d want 1 1", busy[0], dut_in[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy[0], done[0], pass[0], fail_count[0], first_fail_idx[0],
           first_fail_valid[0], dut_in[0]} !== 11'b0) begin
         errors++;
         $display("FAIL midrst_async got busy=%b done=%b pass=%b fc=%0d ffi=%0d ffv=%b dut_in=%0d want all 0",
                  busy[0], done[0], pass[0], fail_count[0], first_fail_idx[0],
                  first_fail_valid[0], dut_in[0]);
      end
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done[0] !== 1'b0) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (done[0] !== 1'b0 || busy[0] !== 1'b0) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         errors++; $display("FAIL midrst_no_done got activity=%b want 0", saw_done);
      end
      pulse_start(0);
      watch_run(0, 0);
      checks++;
      if (cyc !== 8 || seq_packed[15:0] !== 16'h05AF || done[0] !== 1'b1 || pass[0] !== 1'b1) begin
         errors++;
         $display("FAIL midrst_rerun got len=%0d seq=%h done=%b pass=%b want 8 05af 1 1",
                  cyc, seq_packed[15:0], done[0], pass[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_start_while_busy();
      int total_dones;
      sel = 0;
      pulse_start(0);
      watch_run(2, 5);
      total_dones = busy_dones + (done[0] === 1'b1 ? 1 : 0);
      checks++;
      if (cyc !== 8) begin
         errors++; $display("FAIL busy_start_len got %0d want 8", cyc);
      end
      @(negedge clk);
      checks++;
      if (done[0] === 1'b1) total_dones++;
      if (total_dones !== 1 || busy[0] !== 1'b0 || pass[0] !== 1'b1) begin
         errors++;
         $display("FAIL busy_start_done got dones=%0d busy=%b pass=%b want 1 0 1",
                  total_dones, busy[0], pass[0]);
      end
   endtask

   initial begin
      test_reset();
      test_and_pass();
      test_expect_mismatch();
      test_stuck_high();
      test_all_fail();
      test_back_to_back();
      test_reset_mid_run();
      test_start_while_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
